// File: rtl/i2c_req_arbiter_pkg.sv
// i2c_pkg: shared arbiter state type and default bus widths
package i2c_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester-side and master-side signals of the shared I2C path
interface i2c_req_arbiter_if
    import i2c_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = I2C_ADDR_W,
    parameter int DATA_W = I2C_DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_din;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        err;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   mst_start;
    logic                   mst_wr;
    logic [ADDR_W-1:0]      mst_addr;
    logic [DATA_W-1:0]      mst_din;
    logic                   mst_done;
    logic [DATA_W-1:0]      mst_datard;
    modport master (
        output req, req_wr, req_addr, req_din, mst_done, mst_datard,
        input  gnt, ack, err, rdata, busy, mst_start, mst_wr, mst_addr, mst_din
    );
    modport slave (
        input  req, req_wr, req_addr, req_din, mst_done, mst_datard,
        output gnt, ack, err, rdata, busy, mst_start, mst_wr, mst_addr, mst_din
    );
endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// rr_pick: first set request at or above ptr, wrapping, as one-hot and index
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);
    localparam int PW = $clog2(NREQ);
    int w_j;
    always_comb begin
        o_idx = '0;
        w_j = 0;
        // descending scan so the closest requester to ptr is written last
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_j]) o_idx = PW'(w_j);
        end
        o_any = |i_req;
        o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master among NREQ requesters,
// with latched transaction fields and a WAIT-state watchdog
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = I2C_ADDR_W,
    parameter int DATA_W  = I2C_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input logic           clk,
    input logic           rst,
    i2c_req_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    arb_state_t        r_state;
    logic [PW-1:0]     r_ptr, r_idx, w_idx;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_gnt, r_ack, r_err, w_grant;
    logic              r_wr, r_start, r_busy, w_any;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din, r_rdata;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_wr    <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: if (w_any) begin
                    r_gnt   <= w_grant;
                    r_idx   <= w_idx;
                    r_wr    <= bus.req_wr[w_idx];
                    r_addr  <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                    r_din   <= bus.req_din[int'(w_idx)*DATA_W +: DATA_W];
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= ARB_ISSUE;
                end
                ARB_ISSUE: begin
                    r_start <= 1'b0;
                    r_timer <= '0;
                    r_state <= ARB_WAIT;
                end
                ARB_WAIT: if (bus.mst_done) begin
                    r_ack   <= r_gnt;
                    r_rdata <= r_wr ? r_rdata : bus.mst_datard;
                    r_state <= ARB_RESP;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    r_err   <= r_gnt;
                    r_state <= ARB_RESP;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
                ARB_RESP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + PW'(1);
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.mst_start = r_start;
    assign bus.mst_wr    = r_wr;
    assign bus.mst_addr  = r_addr;
    assign bus.mst_din   = r_din;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized transactions against a round-robin reference model
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int OW = 3 * N + DW + 3 + AW + DW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int ptr = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic          wr_a   [N];
    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] din_a  [N];

    i2c_req_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    i2c_req_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [OW-1:0] outs();
        return {bus.gnt, bus.ack, bus.err, bus.rdata, bus.busy, bus.mst_start,
                bus.mst_wr, bus.mst_addr, bus.mst_din};
    endfunction

    task automatic apply(input logic [N-1:0] m);
        bus.req = m;
        for (int i = 0; i < N; i++) begin
            bus.req_wr[i] = wr_a[i];
            bus.req_addr[i*AW +: AW] = addr_a[i];
            bus.req_din[i*DW +: DW] = din_a[i];
        end
    endtask

    // starts at the first WAIT cycle; returns at the cycle where ack/err should show
    task automatic serve(input int j, input logic [DW-1:0] rd);
        if (j < TO) begin
            repeat (j) @(negedge clk);
            bus.mst_done = 1'b1;
            bus.mst_datard = rd;
            @(negedge clk);
            bus.mst_done = 1'b0;
            bus.mst_datard = DW'($urandom);
        end else begin
            repeat (TO) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.mst_done = 1'b0;
        bus.mst_datard = '0;
        for (int i = 0; i < N; i++) begin
            wr_a[i] = 1'b0;
            addr_a[i] = '0;
            din_a[i] = '0;
        end
        apply('0);
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        rst = 1'b0;
        ptr = 0;
        exp_rdata = '0;
    endtask

    task automatic test_single_write;
        wr_a[0] = 1'b1; addr_a[0] = 7'h12; din_a[0] = 8'hA5;
        apply(4'b0001);
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.mst_start, bus.busy, bus.mst_wr, bus.mst_addr, bus.mst_din} !==
            {4'b0001, 3'b111, 7'h12, 8'hA5}) begin
            failures++;
            $display("FAIL wr_issue got=%b %b %b %b %h %h exp=0001 1 1 1 12 a5", bus.gnt,
                     bus.mst_start, bus.busy, bus.mst_wr, bus.mst_addr, bus.mst_din);
        end
        addr_a[0] = 7'h55; din_a[0] = 8'h00;
        apply(4'b0001);
        @(negedge clk);
        checks++;
        if ({bus.mst_start, bus.mst_addr, bus.mst_din, bus.gnt} !== {1'b0, 7'h12, 8'hA5, 4'b0001}) begin
            failures++;
            $display("FAIL wr_hold got=%b %h %h %b exp=0 12 a5 0001", bus.mst_start,
                     bus.mst_addr, bus.mst_din, bus.gnt);
        end
        serve(5, 8'h3C);
        checks++;
        if ({bus.ack, bus.err, bus.gnt, bus.rdata} !== {4'b0001, 4'b0000, 4'b0001, exp_rdata}) begin
            failures++;
            $display("FAIL wr_ack got=%b %b %b %h exp=0001 0000 0001 %h", bus.ack, bus.err,
                     bus.gnt, bus.rdata, exp_rdata);
        end
        apply('0);
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.gnt, bus.busy} !== '0) begin
            failures++;
            $display("FAIL wr_release got=%b %b %b exp=0000 0000 0", bus.ack, bus.gnt, bus.busy);
        end
        ptr = 1;
    endtask

    task automatic test_read;
        logic [N-1:0] oh;
        wr_a[2] = 1'b0; addr_a[2] = 7'h12;
        wr_a[0] = 1'b1;
        apply(4'b0101);
        oh = 4'b1 << pick(4'b0101, ptr);
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.mst_wr, bus.mst_addr} !== {oh, 1'b0, 7'h12}) begin
            failures++;
            $display("FAIL rd_grant got=%b %b %h exp=%b 0 12", bus.gnt, bus.mst_wr, bus.mst_addr, oh);
        end
        @(negedge clk);
        serve(2, 8'hA5);
        checks++;
        if ({bus.ack, bus.err, bus.rdata} !== {4'b0100, 4'b0000, 8'hA5}) begin
            failures++;
            $display("FAIL rd_ack got=%b %b %h exp=0100 0000 a5", bus.ack, bus.err, bus.rdata);
        end
        exp_rdata = 8'hA5;
        apply('0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bus.rdata, bus.ack, bus.gnt} !== {exp_rdata, 8'h00}) begin
                failures++;
                $display("FAIL rd_hold got=%h %b %b exp=%h 0000 0000", bus.rdata, bus.ack,
                         bus.gnt, exp_rdata);
            end
        end
        ptr = 3;
    endtask

    task automatic test_fairness;
        logic [N-1:0] oh;
        logic [DW-1:0] rd;
        int w;
        for (int i = 0; i < N; i++) wr_a[i] = 1'b0;
        apply(4'b1111);
        for (int t = 0; t < N + 1; t++) begin
            w = pick(4'b1111, ptr);
            oh = 4'b1 << w;
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.busy, bus.mst_start} !== {oh, 2'b11}) begin
                failures++;
                $display("FAIL fair_grant t=%0d got=%b exp=%b", t, bus.gnt, oh);
            end
            @(negedge clk);
            rd = DW'($urandom);
            serve(int'($urandom_range(0, 4)), rd);
            checks++;
            if ({bus.ack, bus.gnt, bus.err, bus.rdata} !== {oh, oh, 4'b0000, rd}) begin
                failures++;
                $display("FAIL fair_ack t=%0d got=%b %b %b %h exp=%b %b 0000 %h", t, bus.ack,
                         bus.gnt, bus.err, bus.rdata, oh, oh, rd);
            end
            exp_rdata = rd;
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.ack} !== '0) begin
                failures++;
                $display("FAIL fair_release t=%0d got=%b %b exp=0000 0000", t, bus.gnt, bus.ack);
            end
            ptr = (w + 1) % N;
        end
        apply('0);
    endtask

    task automatic test_timeout;
        logic seen;
        wr_a[1] = 1'b0;
        apply(4'b0010);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL to_grant got=%b exp=0010", bus.gnt);
        end
        @(negedge clk);
        seen = 1'b0;
        repeat (TO - 1) begin
            @(negedge clk);
            if (|{bus.ack, bus.err}) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL to_early got=1 exp=0");
        end
        @(negedge clk);
        checks++;
        if ({bus.err, bus.ack, bus.rdata} !== {4'b0010, 4'b0000, exp_rdata}) begin
            failures++;
            $display("FAIL to_err got=%b %b %h exp=0010 0000 %h", bus.err, bus.ack, bus.rdata, exp_rdata);
        end
        apply('0);
        @(negedge clk);
        checks++;
        if ({bus.err, bus.busy} !== '0) begin
            failures++;
            $display("FAIL to_release got=%b %b exp=0000 0", bus.err, bus.busy);
        end
        ptr = 2;
    endtask

    task automatic test_done_at_timeout;
        wr_a[3] = 1'b0;
        apply(4'b1000);
        repeat (2) @(negedge clk);
        serve(TO - 1, 8'h5A);
        checks++;
        if ({bus.ack, bus.err, bus.rdata} !== {4'b1000, 4'b0000, 8'h5A}) begin
            failures++;
            $display("FAIL dat_ack got=%b %b %h exp=1000 0000 5a", bus.ack, bus.err, bus.rdata);
        end
        exp_rdata = 8'h5A;
        apply('0);
        @(negedge clk);
        ptr = 0;
    endtask

    task automatic test_reset_wait;
        wr_a[1] = 1'b1;
        apply(4'b0010);
        repeat (2) @(negedge clk);
        serve(1, 8'h00);
        checks++;
        if (bus.ack !== 4'b0010) begin
            failures++;
            $display("FAIL rw_pre got=%b exp=0010", bus.ack);
        end
        apply('0);
        @(negedge clk);
        wr_a[2] = 1'b1;
        apply(4'b0100);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL rw_async got=%h exp=0", outs());
        end
        apply('0);
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        exp_rdata = '0;
        wr_a[0] = 1'b1;
        apply(4'b0101);
        @(negedge clk);
        checks++;
        if (bus.gnt !== (4'b1 << pick(4'b0101, ptr))) begin
            failures++;
            $display("FAIL rw_ptr got=%b exp=0001", bus.gnt);
        end
        @(negedge clk);
        serve(0, 8'h00);
        checks++;
        if ({bus.ack, bus.rdata} !== {4'b0001, exp_rdata}) begin
            failures++;
            $display("FAIL rw_ack got=%b %h exp=0001 %h", bus.ack, bus.rdata, exp_rdata);
        end
        apply('0);
        @(negedge clk);
        ptr = 1;
    endtask

    task automatic test_random;
        logic [N-1:0] m, oh, ea, ee;
        logic [DW-1:0] rd, sd;
        logic [AW-1:0] sa;
        logic sw;
        int w, j;
        for (int it = 0; it < 40; it++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                wr_a[i] = 1'($urandom);
                addr_a[i] = AW'($urandom);
                din_a[i] = DW'($urandom);
            end
            apply(m);
            w = pick(m, ptr);
            oh = 4'b1 << w;
            sw = wr_a[w]; sa = addr_a[w]; sd = din_a[w];
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.mst_start, bus.busy, bus.mst_wr, bus.mst_addr, bus.mst_din} !==
                {oh, 2'b11, sw, sa, sd}) begin
                failures++;
                $display("FAIL rand_issue it=%0d got=%b %b %h %h exp=%b %b %h %h", it, bus.gnt,
                         bus.mst_wr, bus.mst_addr, bus.mst_din, oh, sw, sa, sd);
            end
            for (int i = 0; i < N; i++) begin
                wr_a[i] = 1'($urandom);
                addr_a[i] = AW'($urandom);
                din_a[i] = DW'($urandom);
            end
            apply(N'($urandom));
            @(negedge clk);
            checks++;
            if ({bus.mst_start, bus.mst_wr, bus.mst_addr, bus.mst_din, bus.gnt} !==
                {1'b0, sw, sa, sd, oh}) begin
                failures++;
                $display("FAIL rand_hold it=%0d got=%b %h %h %b exp=%b %h %h %b", it, bus.mst_wr,
                         bus.mst_addr, bus.mst_din, bus.gnt, sw, sa, sd, oh);
            end
            j = int'($urandom_range(0, TO + 2));
            rd = DW'($urandom);
            serve(j, rd);
            ea = (j < TO) ? oh : '0;
            ee = (j < TO) ? '0 : oh;
            if (j < TO && !sw) exp_rdata = rd;
            checks++;
            if ({bus.ack, bus.err, bus.rdata} !== {ea, ee, exp_rdata}) begin
                failures++;
                $display("FAIL rand_resp it=%0d j=%0d got=%b %b %h exp=%b %b %h", it, j, bus.ack,
                         bus.err, bus.rdata, ea, ee, exp_rdata);
            end
            @(negedge clk);
            checks++;
            if ({bus.gnt, bus.ack, bus.err, bus.busy} !== '0) begin
                failures++;
                $display("FAIL rand_idle it=%0d got=%b %b %b %b exp=0", it, bus.gnt, bus.ack,
                         bus.err, bus.busy);
            end
            ptr = (w + 1) % N;
        end
        apply('0);
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_read;
        test_fairness;
        test_timeout;
        test_done_at_timeout;
        test_reset_wait;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
